// File: rtl/instruction_fetch_stage_pkg.sv
// Shared widths for the instruction fetch stage and its sign-extender.
package instruction_fetch_stage_pkg;
    localparam int WIDTH_B_DEF = 32;
    localparam int ADDR_B_DEF  = 10;
    localparam int JUMP_W      = 26;
    localparam int IMM_W       = 16;
endpackage

// File: rtl/instruction_fetch_stage_sext.sv
// Sign-extends an IN_W-bit immediate to OUT_W bits.
module instruction_fetch_stage_sext
    import instruction_fetch_stage_pkg::*;
#(
    parameter int IN_W  = IMM_W,
    parameter int OUT_W = WIDTH_B_DEF
) (
    input  logic [IN_W-1:0]  i_imm,
    output logic [OUT_W-1:0] o_ext
);
    assign o_ext = {{(OUT_W-IN_W){i_imm[IN_W-1]}}, i_imm};
endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: PC select, synchronous-ROM addressing and IF/ID pipeline register.
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter int               WIDTH_B  = WIDTH_B_DEF,
    parameter int               ADDR_B   = ADDR_B_DEF,
    parameter logic [WIDTH_B-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [WIDTH_B-1:0] branch_target,
    input  logic               jump_taken,
    input  logic [JUMP_W-1:0]  jump_index,
    output logic [ADDR_B-1:0]  imem_addr,
    input  logic [WIDTH_B-1:0] imem_data,
    output logic               id_valid,
    output logic [WIDTH_B-1:0] id_instr,
    output logic [WIDTH_B-1:0] id_pc_plus1,
    output logic [WIDTH_B-1:0] id_sign_ext,
    output logic [WIDTH_B-1:0] pc_debug
);
    logic [WIDTH_B-1:0] r_pc;
    logic [WIDTH_B-1:0] r_id_instr;
    logic [WIDTH_B-1:0] r_id_pc_plus1;
    logic [WIDTH_B-1:0] r_id_sign_ext;
    logic               r_fetch_valid;
    logic               r_id_valid;

    logic [WIDTH_B-1:0] w_pc_plus1;
    logic [WIDTH_B-1:0] w_jump_pc;
    logic [WIDTH_B-1:0] w_pc_next;
    logic [WIDTH_B-1:0] w_sext;
    logic               w_redirect;

    assign w_pc_plus1 = r_pc + {{(WIDTH_B-1){1'b0}}, 1'b1};
    assign w_jump_pc  = {r_id_pc_plus1[WIDTH_B-1:JUMP_W], jump_index};
    assign w_redirect = branch_taken | jump_taken;

    // Branch outranks jump: it comes from the older instruction in EX.
    always_comb begin
        w_pc_next = w_pc_plus1;
        if (rst)
            w_pc_next = RESET_PC;
        else if (branch_taken)
            w_pc_next = branch_target;
        else if (jump_taken)
            w_pc_next = w_jump_pc;
        else if (stall)
            w_pc_next = r_pc;
    end

    // Addressing the ROM with pc_next lines imem_data up with pc one cycle later.
    assign imem_addr = w_pc_next[ADDR_B-1:0];

    instruction_fetch_stage_sext #(
        .IN_W  (IMM_W),
        .OUT_W (WIDTH_B)
    ) u_sext (
        .i_imm (imem_data[IMM_W-1:0]),
        .o_ext (w_sext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_fetch_valid <= 1'b0;
            r_id_valid    <= 1'b0;
            r_id_instr    <= '0;
            r_id_pc_plus1 <= '0;
            r_id_sign_ext <= '0;
        end else begin
            r_pc          <= w_pc_next;
            r_fetch_valid <= 1'b1;
            if (w_redirect) begin
                r_id_valid <= 1'b0;
            end else if (!stall) begin
                r_id_valid    <= r_fetch_valid;
                r_id_instr    <= imem_data;
                r_id_pc_plus1 <= w_pc_plus1;
                r_id_sign_ext <= w_sext;
            end
        end
    end

    assign id_valid    = r_id_valid;
    assign id_instr    = r_id_instr;
    assign id_pc_plus1 = r_id_pc_plus1;
    assign id_sign_ext = r_id_sign_ext;
    assign pc_debug    = r_pc;
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed vector bench for instruction_fetch_stage with a 1-cycle synchronous ROM model.
module tb_instruction_fetch_stage;
    logic        clk = 1'b0;
    logic        rst, stall, branch_taken, jump_taken;
    logic [31:0] branch_target;
    logic [25:0] jump_index;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data;
    logic        id_valid;
    logic [31:0] id_instr, id_pc_plus1, id_sign_ext, pc_debug;

    logic [31:0] rom [1024];
    int tests = 0;
    int errors = 0;

    instruction_fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump_taken    (jump_taken),
        .jump_index    (jump_index),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .id_valid      (id_valid),
        .id_instr      (id_instr),
        .id_pc_plus1   (id_pc_plus1),
        .id_sign_ext   (id_sign_ext),
        .pc_debug      (pc_debug)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= rom[imem_addr];

    typedef struct {
        logic        r, s, b;
        logic [31:0] tgt;
        logic        j;
        logic [25:0] ji;
        logic        ca;
        logic [9:0]  addr;
        logic        v;
        logic [31:0] instr, pcp1, pc;
    } vec_t;

    vec_t vecs [40];
    int   nv = 0;

    function automatic logic [31:0] sext16(input logic [31:0] x);
        return {{16{x[15]}}, x[15:0]};
    endfunction

    task automatic add(input logic r, s, b, input logic [31:0] tgt, input logic j,
                       input logic [25:0] ji, input logic ca, input logic [9:0] addr,
                       input logic v, input logic [31:0] instr, pcp1, pc);
        vecs[nv] = '{r, s, b, tgt, j, ji, ca, addr, v, instr, pcp1, pc};
        nv++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, s, b, input logic [31:0] tgt, input logic j,
                         input logic [25:0] ji);
        rst = r; stall = s; branch_taken = b; branch_target = tgt;
        jump_taken = j; jump_index = ji;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = i;
        rom[32'h60] = 32'h1234_8000;
        drive(1, 0, 0, 0, 0, 0);

        //  r s b tgt           j ji      ca addr    v instr          pcp1          pc
        add(1,0,0,32'h0,        0,26'h0,  1,10'h0,   0,32'h0,        32'h0,        32'h0);
        add(1,0,0,32'h0,        0,26'h0,  0,10'h0,   0,32'h0,        32'h0,        32'h0);
        add(0,0,0,32'h0,        0,26'h0,  0,10'h0,   0,32'h0,        32'h1,        32'h1);
        add(0,0,0,32'h0,        0,26'h0,  0,10'h0,   1,32'h1,        32'h2,        32'h2);
        add(0,0,0,32'h0,        0,26'h0,  0,10'h0,   1,32'h2,        32'h3,        32'h3);
        add(0,0,0,32'h0,        0,26'h0,  0,10'h0,   1,32'h3,        32'h4,        32'h4);
        add(0,0,0,32'h0,        0,26'h0,  0,10'h0,   1,32'h4,        32'h5,        32'h5);
        add(0,0,0,32'h0,        0,26'h0,  0,10'h0,   1,32'h5,        32'h6,        32'h6);
        add(0,1,0,32'h0,        0,26'h0,  1,10'h6,   1,32'h5,        32'h6,        32'h6);
        add(0,1,0,32'h0,        0,26'h0,  1,10'h6,   1,32'h5,        32'h6,        32'h6);
        add(0,1,0,32'h0,        0,26'h0,  1,10'h6,   1,32'h5,        32'h6,        32'h6);
        add(0,0,0,32'h0,        0,26'h0,  0,10'h0,   1,32'h6,        32'h7,        32'h7);
        add(0,0,0,32'h0,        0,26'h0,  0,10'h0,   1,32'h7,        32'h8,        32'h8);
        add(0,0,1,32'h40,       0,26'h0,  1,10'h40,  0,32'h7,        32'h8,        32'h40);
        add(0,0,0,32'h0,        0,26'h0,  0,10'h0,   1,32'h40,       32'h41,       32'h41);
        add(0,0,0,32'h0,        0,26'h0,  0,10'h0,   1,32'h41,       32'h42,       32'h42);
        add(0,1,1,32'h60,       1,26'h3,  1,10'h60,  0,32'h41,       32'h42,       32'h60);
        add(0,0,0,32'h0,        0,26'h0,  0,10'h0,   1,32'h1234_8000,32'h61,       32'h61);
        add(0,0,0,32'h0,        0,26'h0,  0,10'h0,   1,32'h61,       32'h62,       32'h62);
        add(0,0,0,32'h0,        1,26'h10, 1,10'h10,  0,32'h61,       32'h62,       32'h10);
        add(0,0,0,32'h0,        0,26'h0,  0,10'h0,   1,32'h10,       32'h11,       32'h11);
        add(0,0,1,32'h0400_0010,0,26'h0,  1,10'h10,  0,32'h10,       32'h11,       32'h0400_0010);
        add(0,0,0,32'h0,        0,26'h0,  0,10'h0,   1,32'h10,       32'h0400_0011,32'h0400_0011);
        add(0,0,0,32'h0,        1,26'h5,  1,10'h5,   0,32'h10,       32'h0400_0011,32'h0400_0005);
        add(0,0,0,32'h0,        0,26'h0,  0,10'h0,   1,32'h5,        32'h0400_0006,32'h0400_0006);
        add(0,1,0,32'h0,        1,26'h20, 1,10'h20,  0,32'h5,        32'h0400_0006,32'h0400_0020);
        add(0,0,0,32'h0,        0,26'h0,  0,10'h0,   1,32'h20,       32'h0400_0021,32'h0400_0021);
        add(1,1,1,32'h80,       0,26'h0,  1,10'h0,   0,32'h0,        32'h0,        32'h0);
        add(0,0,0,32'h0,        0,26'h0,  0,10'h0,   0,32'h0,        32'h1,        32'h1);
        add(0,0,0,32'h0,        1,26'h3FF,1,10'h3FF, 0,32'h0,        32'h1,        32'h3FF);
        add(0,0,0,32'h0,        0,26'h0,  1,10'h0,   1,32'h3FF,      32'h400,      32'h400);
        add(0,0,0,32'h0,        0,26'h0,  1,10'h1,   1,32'h0,        32'h401,      32'h401);

        for (int k = 0; k < nv; k++) begin
            @(negedge clk);
            drive(vecs[k].r, vecs[k].s, vecs[k].b, vecs[k].tgt, vecs[k].j, vecs[k].ji);
            #1;
            if (vecs[k].ca) chk($sformatf("v%0d imem_addr", k), {22'd0, imem_addr}, {22'd0, vecs[k].addr});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d id_valid", k), {31'd0, id_valid}, {31'd0, vecs[k].v});
            chk($sformatf("v%0d id_instr", k), id_instr, vecs[k].instr);
            chk($sformatf("v%0d id_pc_plus1", k), id_pc_plus1, vecs[k].pcp1);
            chk($sformatf("v%0d id_sign_ext", k), id_sign_ext, sext16(vecs[k].instr));
            chk($sformatf("v%0d pc_debug", k), pc_debug, vecs[k].pc);
        end

        // Reset release: count edges until id_valid, bounded.
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        begin
            int edges = 0;
            while (!id_valid && edges < 10) begin
                @(posedge clk);
                #1;
                edges++;
            end
            chk("valid_rise_edge", edges, 2);
            chk("first_valid_instr", id_instr, 32'h1);
            chk("first_valid_pcp1", id_pc_plus1, id_instr + 32'h1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
